rename_rollback_ctrl: RTL and testbench

- History buffer and recovery sequencer for the register rename stage.
- Records one entry {arch_reg, old_phys, new_phys} per renamed instruction that has a destination register.
- On retire: releases the head entry's old_phys to the free list.
- On a flush: walks the buffer from youngest to oldest squashed entry, one entry per cycle. Each step restores the alias table (arch_reg <- old_phys) and frees the squashed new_phys. Rename is stalled for the whole walk.

---
 rtl/rename_rollback_ctrl.sv | 139 +++++++++++++
 tb/tb_rename_rollback_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rollback_ctrl.sv
// Rename history buffer: records {arch, old_phys, new_phys} per allocation, frees old_phys on
// retire, and on a flush walks youngest-to-oldest restoring the alias table one entry per cycle.
module rename_rollback_ctrl #(
    parameter int unsigned Depth = 16,
    parameter int unsigned PtrW  = 4,
    parameter int unsigned PregW = 6,
    parameter int unsigned AregW = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             alloc_valid_i,
    input  logic [AregW-1:0] alloc_arch_reg_i,
    input  logic [PregW-1:0] alloc_new_phys_i,
    input  logic [PregW-1:0] alloc_old_phys_i,
    output logic             alloc_ready_o,
    output logic [PtrW-1:0]  alloc_tag_o,

    input  logic             retire_valid_i,
    output logic             free_valid_o,
    output logic [PregW-1:0] free_phys_o,

    input  logic             flush_valid_i,
    input  logic [PtrW-1:0]  flush_tag_i,
    output logic             restore_valid_o,
    output logic [AregW-1:0] restore_arch_reg_o,
    output logic [PregW-1:0] restore_phys_o,
    output logic             squash_free_valid_o,
    output logic [PregW-1:0] squash_free_phys_o,

    output logic             rename_stall_o,
    output logic             walk_done_o,
    output logic [PtrW:0]    count_o
);

    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

    localparam logic [PtrW:0] PtrOne   = (PtrW+1)'(1);
    localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);

    state_e state_q, state_d;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0]   head_q, head_d;
    logic [PtrW:0]   tail_q, tail_d;
    logic [PtrW:0]   walk_ptr_q, walk_ptr_d;
    logic [PtrW-1:0] stop_q, stop_d;

    logic [AregW-1:0] arch_mem_q [Depth];
    logic [PregW-1:0] old_mem_q  [Depth];
    logic [PregW-1:0] new_mem_q  [Depth];

    logic full, empty, alloc_fire;
    logic [PtrW-1:0] head_idx, tail_idx, walk_idx;

    assign head_idx = head_q[PtrW-1:0];
    assign tail_idx = tail_q[PtrW-1:0];
    assign walk_idx = walk_ptr_q[PtrW-1:0];

    assign count_o = tail_q - head_q;
    assign full    = (count_o == DepthCnt);
    assign empty   = (count_o == '0);

    assign alloc_ready_o = (state_q == StIdle) && !full && !flush_valid_i;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o   = tail_idx;

    assign free_valid_o = retire_valid_i && !empty;
    assign free_phys_o  = old_mem_q[head_idx];

    // Walk strobes come only from state so a new flush cannot glitch them.
    assign restore_valid_o     = (state_q == StWalk);
    assign squash_free_valid_o = (state_q == StWalk);
    assign restore_arch_reg_o  = arch_mem_q[walk_idx];
    assign restore_phys_o      = old_mem_q[walk_idx];
    assign squash_free_phys_o  = new_mem_q[walk_idx];

    assign walk_done_o    = (state_q == StDone);
    assign rename_stall_o = (state_q != StIdle) || flush_valid_i;

    always_comb begin
        state_d    = state_q;
        head_d     = free_valid_o ? head_q + PtrOne : head_q;
        tail_d     = tail_q;
        walk_ptr_d = walk_ptr_q;
        stop_d     = stop_q;
        unique case (state_q)
            StIdle: begin
                if (alloc_fire) begin
                    tail_d = tail_q + PtrOne;
                end
                if (flush_valid_i) begin
                    walk_ptr_d = tail_q - PtrOne;
                    stop_d     = flush_tag_i;
                    state_d    = (flush_tag_i == tail_idx) ? StDone : StWalk;
                end
            end
            StWalk: begin
                tail_d     = walk_ptr_q;
                walk_ptr_d = walk_ptr_q - PtrOne;
                if (walk_idx == stop_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= '0;
            walk_ptr_q <= '0;
            stop_q     <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            walk_ptr_q <= walk_ptr_d;
            stop_q     <= stop_d;
        end
    end

    // Entry storage needs no reset; contents are qualified by the pointers.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            arch_mem_q[tail_idx] <= alloc_arch_reg_i;
            old_mem_q[tail_idx]  <= alloc_old_phys_i;
            new_mem_q[tail_idx]  <= alloc_new_phys_i;
        end
    end

endmodule

// File: tb/tb_rename_rollback_ctrl.sv
// Directed bench for rename_rollback_ctrl: allocate, retire, flush walks, full, wrap and reset.
module tb_rename_rollback_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       alloc_valid_i;
    logic [4:0] alloc_arch_reg_i;
    logic [5:0] alloc_new_phys_i;
    logic [5:0] alloc_old_phys_i;
    logic       alloc_ready_o;
    logic [3:0] alloc_tag_o;
    logic       retire_valid_i;
    logic       free_valid_o;
    logic [5:0] free_phys_o;
    logic       flush_valid_i;
    logic [3:0] flush_tag_i;
    logic       restore_valid_o;
    logic [4:0] restore_arch_reg_o;
    logic [5:0] restore_phys_o;
    logic       squash_free_valid_o;
    logic [5:0] squash_free_phys_o;
    logic       rename_stall_o;
    logic       walk_done_o;
    logic [4:0] count_o;

    int n_checks = 0;
    int n_fails  = 0;

    rename_rollback_ctrl dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_arch_reg_i    (alloc_arch_reg_i),
        .alloc_new_phys_i    (alloc_new_phys_i),
        .alloc_old_phys_i    (alloc_old_phys_i),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_tag_o         (alloc_tag_o),
        .retire_valid_i      (retire_valid_i),
        .free_valid_o        (free_valid_o),
        .free_phys_o         (free_phys_o),
        .flush_valid_i       (flush_valid_i),
        .flush_tag_i         (flush_tag_i),
        .restore_valid_o     (restore_valid_o),
        .restore_arch_reg_o  (restore_arch_reg_o),
        .restore_phys_o      (restore_phys_o),
        .squash_free_valid_o (squash_free_valid_o),
        .squash_free_phys_o  (squash_free_phys_o),
        .rename_stall_o      (rename_stall_o),
        .walk_done_o         (walk_done_o),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input int arch, input int newp, input int oldp);
        alloc_valid_i    = 1'b1;
        alloc_arch_reg_i = 5'(arch);
        alloc_new_phys_i = 6'(newp);
        alloc_old_phys_i = 6'(oldp);
        tick();
        alloc_valid_i    = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 rst_ni = 1'b0;
        #1 rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        alloc_valid_i = 1'b0; alloc_arch_reg_i = '0; alloc_new_phys_i = '0; alloc_old_phys_i = '0;
        retire_valid_i = 1'b0; flush_valid_i = 1'b0; flush_tag_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_count", count_o, 0);
        check_eq("rst_tag", alloc_tag_o, 0);
        check_eq("rst_restore", restore_valid_o, 0);
        check_eq("rst_done", walk_done_o, 0);
        check_eq("rst_stall", rename_stall_o, 0);
        rst_ni = 1'b1;
        #1;
        check_eq("rst_ready", alloc_ready_o, 1);

        // Three allocations, tags 0..2.
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1'b1; alloc_arch_reg_i = 5'(i + 1);
            alloc_new_phys_i = 6'(32 + i); alloc_old_phys_i = 6'(i + 1);
            #1;
            check_eq("a3_tag", alloc_tag_o, i);
            check_eq("a3_ready", alloc_ready_o, 1);
            tick();
        end
        alloc_valid_i = 1'b0;
        check_eq("a3_count", count_o, 3);

        // Two retires release old_phys 1 then 2.
        retire_valid_i = 1'b1;
        #1;
        check_eq("ret1_valid", free_valid_o, 1);
        check_eq("ret1_phys", free_phys_o, 1);
        tick();
        check_eq("ret2_valid", free_valid_o, 1);
        check_eq("ret2_phys", free_phys_o, 2);
        tick();
        retire_valid_i = 1'b0;
        check_eq("ret_count", count_o, 1);

        // Fresh buffer, four entries, flush from tag 1.
        pulse_reset();
        for (int i = 0; i < 4; i++) do_alloc(i, 40 + i, 10 + i);
        flush_valid_i = 1'b1; flush_tag_i = 4'd1;
        #1;
        check_eq("fl_ready", alloc_ready_o, 0);
        check_eq("fl_stall0", rename_stall_o, 1);
        check_eq("fl_norestore0", restore_valid_o, 0);
        tick();
        flush_valid_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_eq("fl_rvalid", restore_valid_o, 1);
            check_eq("fl_svalid", squash_free_valid_o, 1);
            check_eq("fl_arch", restore_arch_reg_o, 3 - s);
            check_eq("fl_phys", restore_phys_o, 13 - s);
            check_eq("fl_sq", squash_free_phys_o, 43 - s);
            check_eq("fl_done_lo", walk_done_o, 0);
            tick();
        end
        check_eq("fl_done", walk_done_o, 1);
        check_eq("fl_restore_off", restore_valid_o, 0);
        check_eq("fl_stall_done", rename_stall_o, 1);
        tick();
        check_eq("fl_done_end", walk_done_o, 0);
        check_eq("fl_stall_end", rename_stall_o, 0);
        check_eq("fl_count", count_o, 1);
        check_eq("fl_next_tag", alloc_tag_o, 1);

        // Fill to full; tag 0 (old 10) still at head.
        for (int i = 1; i < 16; i++) do_alloc(i, i, 20 + i);
        check_eq("full_count", count_o, 16);
        check_eq("full_ready", alloc_ready_o, 0);
        retire_valid_i = 1'b1;
        alloc_valid_i  = 1'b1;
        #1;
        check_eq("full_ret_ready", alloc_ready_o, 0);
        check_eq("full_ret_phys", free_phys_o, 10);
        tick();
        retire_valid_i = 1'b0;
        alloc_valid_i  = 1'b0;
        check_eq("full_after_count", count_o, 15);
        check_eq("full_after_ready", alloc_ready_o, 1);

        // Empty flush: tail index is 0.
        flush_valid_i = 1'b1; flush_tag_i = 4'd0;
        #1;
        check_eq("ef_stall0", rename_stall_o, 1);
        tick();
        flush_valid_i = 1'b0;
        check_eq("ef_restore", restore_valid_o, 0);
        check_eq("ef_done", walk_done_o, 1);
        check_eq("ef_stall1", rename_stall_o, 1);
        tick();
        check_eq("ef_done_end", walk_done_o, 0);
        check_eq("ef_stall_end", rename_stall_o, 0);
        check_eq("ef_count", count_o, 15);

        // Wrap: move head/tail to 14, allocate tags 14,15,0 and flush from 15.
        pulse_reset();
        for (int i = 0; i < 14; i++) do_alloc(0, 0, 0);
        retire_valid_i = 1'b1;
        repeat (14) tick();
        retire_valid_i = 1'b0;
        check_eq("wr_empty", count_o, 0);
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1'b1; alloc_arch_reg_i = 5'(20 + i);
            alloc_new_phys_i = 6'(60 + i); alloc_old_phys_i = 6'(50 + i);
            #1;
            check_eq("wr_tag", alloc_tag_o, (14 + i) % 16);
            tick();
        end
        alloc_valid_i = 1'b0;
        flush_valid_i = 1'b1; flush_tag_i = 4'd15;
        tick();
        flush_valid_i  = 1'b0;
        retire_valid_i = 1'b1;
        #1;
        check_eq("wr_arch0", restore_arch_reg_o, 22);
        check_eq("wr_phys0", restore_phys_o, 52);
        check_eq("wr_sq0", squash_free_phys_o, 62);
        check_eq("wr_free_valid", free_valid_o, 1);
        check_eq("wr_free_phys", free_phys_o, 50);
        tick();
        retire_valid_i = 1'b0;
        check_eq("wr_arch1", restore_arch_reg_o, 21);
        check_eq("wr_phys1", restore_phys_o, 51);
        check_eq("wr_sq1", squash_free_phys_o, 61);
        tick();
        check_eq("wr_done", walk_done_o, 1);
        tick();
        check_eq("wr_count", count_o, 0);

        // Reset in the middle of a walk.
        for (int i = 0; i < 3; i++) do_alloc(i + 1, 8 + i, 5 + i);
        flush_valid_i = 1'b1; flush_tag_i = 4'd0;
        tick();
        flush_valid_i = 1'b0;
        check_eq("mr_walking", restore_valid_o, 1);
        check_eq("mr_arch", restore_arch_reg_o, 3);
        rst_ni = 1'b0;
        #1;
        check_eq("mr_restore", restore_valid_o, 0);
        check_eq("mr_squash", squash_free_valid_o, 0);
        check_eq("mr_done", walk_done_o, 0);
        check_eq("mr_stall", rename_stall_o, 0);
        check_eq("mr_count", count_o, 0);
        rst_ni = 1'b1;
        tick();
        check_eq("mr_after_restore", restore_valid_o, 0);
        check_eq("mr_after_done", walk_done_o, 0);
        check_eq("mr_after_ready", alloc_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
